// File: rtl/seg_scan.sv
// Three-digit multiplexed seven-segment driver with frame-aligned digit update,
// leading-zero blanking, anti-ghosting dead time and invalid-digit flag.
module seg_scan #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEAD     = 2,
    parameter bit          CA       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bai,
    input  logic [3:0] shi,
    input  logic [3:0] ge,
    input  logic       load,
    input  logic       blank_en,
    output logic [6:0] seg,
    output logic [2:0] dig_sel,
    output logic       frame_done,
    output logic       err
);

    localparam int unsigned    PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PCNT_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]  DEAD_CNT = PW'(DEAD);
    localparam logic [6:0]     SEG_OFF  = CA ? 7'h7F : 7'h00;
    localparam logic [2:0]     SEL_OFF  = CA ? 3'b111 : 3'b000;

    typedef enum logic [1:0] {StBai, StShi, StGe} slot_e;

    slot_e         state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [11:0]   pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic [11:0]   disp_q, disp_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    dig_sel_q, dig_sel_d;
    logic          frame_done_q, frame_done_d;
    logic          err_q, err_d;

    logic          wrap;
    logic          frame_wrap;
    logic [3:0]    digit;
    logic          blank;
    logic [2:0]    onehot;
    logic [6:0]    pattern;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    always_comb begin
        wrap       = (pcnt_q == PCNT_MAX);
        pcnt_d     = wrap ? '0 : pcnt_q + 1'b1;
        state_d    = state_q;
        if (wrap) begin
            case (state_q)
                StBai:   state_d = StShi;
                StShi:   state_d = StGe;
                default: state_d = StBai;
            endcase
        end
        frame_wrap = wrap && (state_q == StGe);

        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        disp_d   = disp_q;
        if (load) begin
            pend_d   = {bai, shi, ge};
            pend_v_d = 1'b1;
        end
        // A load coinciding with the frame wrap goes straight to the display.
        if (frame_wrap) begin
            if (load) begin
                disp_d   = {bai, shi, ge};
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                disp_d   = pend_q;
                pend_v_d = 1'b0;
            end
        end
    end

    // Outputs are computed from next-state values so the registered seg/dig_sel
    // line up with the slot and prescaler count they belong to.
    always_comb begin
        digit  = disp_d[3:0];
        blank  = 1'b0;
        onehot = 3'b001;
        case (state_d)
            StBai: begin
                digit  = disp_d[11:8];
                blank  = blank_en && (digit == 4'd0);
                onehot = 3'b100;
            end
            StShi: begin
                digit  = disp_d[7:4];
                blank  = blank_en && (disp_d[11:8] == 4'd0) && (digit == 4'd0);
                onehot = 3'b010;
            end
            default: begin
                digit  = disp_d[3:0];
                blank  = 1'b0;
                onehot = 3'b001;
            end
        endcase
        pattern      = blank ? 7'h00 : decode(digit);
        seg_d        = CA ? ~pattern : pattern;
        dig_sel_d    = (pcnt_d < DEAD_CNT) ? SEL_OFF : (CA ? ~onehot : onehot);
        frame_done_d = (state_d == StGe) && (pcnt_d == PCNT_MAX);
        err_d        = (disp_q[11:8] > 4'd9) || (disp_q[7:4] > 4'd9) || (disp_q[3:0] > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StBai;
            pcnt_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            disp_q       <= '0;
            seg_q        <= SEG_OFF;
            dig_sel_q    <= SEL_OFF;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            disp_q       <= disp_d;
            seg_q        <= seg_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: stimulus pushes expected per-frame slot patterns,
// a monitor checks selects/frame pulse every cycle and pops records at frame end.
module tb_seg_scan;

    localparam int unsigned SD   = 4;
    localparam int unsigned DT   = 1;
    localparam int          FLEN = 3 * SD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] bai = '0, shi = '0, ge = '0;
    logic       load = 1'b0;
    logic       blank_en = 1'b0;

    logic [6:0] seg_ca, seg_cc;
    logic [2:0] sel_ca, sel_cc;
    logic       fd_ca, fd_cc, err_ca, err_cc;

    seg_scan #(.SCAN_DIV(SD), .DEAD(DT), .CA(1'b1)) u_ca (
        .clk(clk), .rst_n(rst_n), .bai(bai), .shi(shi), .ge(ge), .load(load),
        .blank_en(blank_en), .seg(seg_ca), .dig_sel(sel_ca), .frame_done(fd_ca), .err(err_ca)
    );

    seg_scan #(.SCAN_DIV(SD), .DEAD(DT), .CA(1'b0)) u_cc (
        .clk(clk), .rst_n(rst_n), .bai(bai), .shi(shi), .ge(ge), .load(load),
        .blank_en(blank_en), .seg(seg_cc), .dig_sel(sel_cc), .frame_done(fd_cc), .err(err_cc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         fr;
        logic [6:0] sb, ss, sg;
        logic       e0, e1;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n = 0;
    int   epoch = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int fr, input logic [6:0] sb, ss, sg, input logic e0, e1);
        exp_t r;
        r.fr = fr; r.sb = sb; r.ss = ss; r.sg = sg; r.e0 = e0; r.e1 = e1;
        q.push_back(r);
    endtask

    task automatic goto_cyc(input int f, input int c);
        while (n < f * FLEN + c) @(negedge clk);
    endtask

    task automatic load_at(input int f, input int c, input logic [3:0] b, s, g);
        goto_cyc(f, c);
        bai = b; shi = s; ge = g; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Monitor
    logic [6:0] cap_ca[3];
    logic [6:0] cap_cc[3];
    logic       cap_e0, cap_e1;

    always @(negedge clk) begin
        if (rst_n) begin
            int   cyc, slot, p, fr;
            logic [2:0] oh;
            exp_t r;
            cyc  = n % FLEN;
            slot = cyc / SD;
            p    = cyc % SD;
            fr   = epoch * 100 + n / FLEN;
            oh   = (p < DT) ? 3'b000 : (3'b100 >> slot);
            check($sformatf("dig_sel_ca f%0d c%0d", fr, cyc), {5'b0, sel_ca}, {5'b0, ~oh});
            check($sformatf("dig_sel_cc f%0d c%0d", fr, cyc), {5'b0, sel_cc}, {5'b0, oh});
            check($sformatf("frame_done f%0d c%0d", fr, cyc), {7'b0, fd_ca},
                  {7'b0, (cyc == FLEN - 1)});
            if (p == 0) begin
                cap_ca[slot] = seg_ca;
                cap_cc[slot] = seg_cc;
            end
            if (cyc == 0) cap_e0 = err_ca;
            if (cyc == 1) cap_e1 = err_ca;
            if (cyc == FLEN - 1) begin
                while (q.size() > 0 && q[0].fr < fr) begin
                    r = q.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL frame_missed: got frame %0d, expected frame %0d", fr, r.fr);
                end
                if (q.size() > 0 && q[0].fr == fr) begin
                    r = q.pop_front();
                    check($sformatf("seg_bai f%0d", fr), {1'b0, cap_ca[0]}, {1'b0, r.sb});
                    check($sformatf("seg_shi f%0d", fr), {1'b0, cap_ca[1]}, {1'b0, r.ss});
                    check($sformatf("seg_ge f%0d", fr), {1'b0, cap_ca[2]}, {1'b0, r.sg});
                    check($sformatf("seg_bai_cc f%0d", fr), {1'b0, cap_cc[0]}, {1'b0, ~r.sb});
                    check($sformatf("seg_shi_cc f%0d", fr), {1'b0, cap_cc[1]}, {1'b0, ~r.ss});
                    check($sformatf("seg_ge_cc f%0d", fr), {1'b0, cap_cc[2]}, {1'b0, ~r.sg});
                    check($sformatf("err_c0 f%0d", fr), {7'b0, cap_e0}, {7'b0, r.e0});
                    check($sformatf("err_c1 f%0d", fr), {7'b0, cap_e1}, {7'b0, r.e1});
                    check($sformatf("err_cc f%0d", fr), {7'b0, err_cc}, {7'b0, r.e1});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // First bai slot after reset starts with the reset (off) pattern.
        push(0, 7'h7F, 7'h40, 7'h40, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        load_at(0, 5, 4'd1, 4'd2, 4'd3);
        push(1, 7'h79, 7'h24, 7'h30, 1'b0, 1'b0);
        push(2, 7'h79, 7'h24, 7'h30, 1'b0, 1'b0);

        // Load in the shi slot must not tear frame 2.
        load_at(2, 5, 4'd4, 4'd5, 4'd6);
        push(3, 7'h19, 7'h12, 7'h02, 1'b0, 1'b0);

        // Load on the wrap edge bypasses pend.
        load_at(3, FLEN - 1, 4'd7, 4'd8, 4'd9);
        push(4, 7'h78, 7'h00, 7'h10, 1'b0, 1'b0);
        blank_en = 1'b1;

        load_at(4, 3, 4'd0, 4'd0, 4'd7);
        push(5, 7'h7F, 7'h7F, 7'h78, 1'b0, 1'b0);
        goto_cyc(5, 10);
        blank_en = 1'b0;
        push(6, 7'h40, 7'h40, 7'h78, 1'b0, 1'b0);

        goto_cyc(6, 9);
        blank_en = 1'b1;
        load_at(6, 9, 4'd0, 4'd0, 4'd0);
        push(7, 7'h7F, 7'h7F, 7'h40, 1'b0, 1'b0);

        load_at(7, 5, 4'hA, 4'd0, 4'd1);
        push(8, 7'h3F, 7'h40, 7'h79, 1'b0, 1'b1);

        load_at(8, 5, 4'd1, 4'd0, 4'd1);
        push(9, 7'h79, 7'h40, 7'h79, 1'b1, 1'b0);

        load_at(9, 5, 4'd8, 4'd8, 4'd8);
        push(10, 7'h00, 7'h00, 7'h00, 1'b0, 1'b0);

        load_at(10, 5, 4'hA, 4'hA, 4'hA);
        push(11, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b1);

        // Pending load is discarded by the mid-frame reset.
        load_at(12, 2, 4'd1, 4'd2, 4'd3);
        goto_cyc(12, 6);
        blank_en = 1'b0;
        #1 rst_n = 1'b0;
        epoch = 1;
        #1;
        check("rst_seg_ca", {1'b0, seg_ca}, 8'h7F);
        check("rst_sel_ca", {5'b0, sel_ca}, 8'h07);
        check("rst_fd_ca", {7'b0, fd_ca}, 8'h00);
        check("rst_err_ca", {7'b0, err_ca}, 8'h00);
        check("rst_seg_cc", {1'b0, seg_cc}, 8'h00);
        check("rst_sel_cc", {5'b0, sel_cc}, 8'h00);
        push(100, 7'h7F, 7'h40, 7'h40, 1'b0, 1'b0);
        push(101, 7'h40, 7'h40, 7'h40, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        goto_cyc(2, 0);
        check("queue_drained", 8'(q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
